// File: rtl/axis_deheaderizer.sv
// Strips a sideband header flit from an AXI-Stream packet and restores TDEST/TID/TUSER
// on every body flit, emitting through a registered 2-entry skid buffer.
module axis_deheaderizer #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned DEST_WIDTH        = 16,
    parameter int unsigned ID_WIDTH          = 16,
    parameter int unsigned USER_WIDTH        = 8,
    parameter int unsigned ENABLE_TLAST_HACK = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   hdr_TDATA,
    input  logic [DATA_WIDTH/8-1:0] hdr_TKEEP,
    input  logic                    hdr_TLAST,
    input  logic                    hdr_TVALID,
    output logic                    hdr_TREADY,
    output logic [DATA_WIDTH-1:0]   sides_TDATA,
    output logic [DATA_WIDTH/8-1:0] sides_TKEEP,
    output logic                    sides_TLAST,
    output logic                    sides_TVALID,
    output logic [DEST_WIDTH-1:0]   sides_TDEST,
    output logic [ID_WIDTH-1:0]     sides_TID,
    output logic [USER_WIDTH-1:0]   sides_TUSER,
    input  logic                    sides_TREADY,
    output logic [15:0]             drop_count
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ID_LSB     = USER_WIDTH;
    localparam int unsigned DEST_LSB   = USER_WIDTH + ID_WIDTH;
    localparam int unsigned LAST_BIT   = USER_WIDTH + ID_WIDTH + DEST_WIDTH;
    localparam bit          HACK       = (ENABLE_TLAST_HACK != 0);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [DEST_WIDTH-1:0] dest;
        logic [ID_WIDTH-1:0]   id;
        logic [USER_WIDTH-1:0] user;
    } flit_t;

    typedef enum logic {
        WAIT_HDR  = 1'b0,
        WAIT_LAST = 1'b1
    } state_t;

    state_t                state;
    logic [DEST_WIDTH-1:0] hdr_dest;
    logic [ID_WIDTH-1:0]   hdr_id;
    logic [USER_WIDTH-1:0] hdr_user;
    logic                  hdr_last;

    flit_t out_flit;
    flit_t skid_flit;
    logic  out_valid;
    logic  skid_valid;

    logic  accept;
    logic  push;
    logic  out_free;
    logic  full_next;
    logic  drop_hdr;
    flit_t in_flit;

    assign accept   = hdr_TVALID && hdr_TREADY;
    assign push     = accept && (state == WAIT_LAST);
    assign out_free = !out_valid || sides_TREADY;
    assign drop_hdr = !HACK && hdr_TLAST;

    // Body flit carries the sidechannels captured from its own header.
    always_comb begin
        in_flit      = '0;
        in_flit.data = hdr_TDATA;
        in_flit.keep = hdr_TKEEP;
        in_flit.last = HACK ? hdr_last : hdr_TLAST;
        in_flit.dest = hdr_dest;
        in_flit.id   = hdr_id;
        in_flit.user = hdr_user;
    end

    // Buffer occupancy after this edge; ready is the registered "not full" of it.
    always_comb begin
        full_next = 1'b0;
        if (out_free) begin
            full_next = skid_valid && push;
        end else begin
            full_next = skid_valid || push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_HDR;
            hdr_dest   <= '0;
            hdr_id     <= '0;
            hdr_user   <= '0;
            hdr_last   <= 1'b0;
            out_flit   <= '0;
            skid_flit  <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            hdr_TREADY <= 1'b0;
            drop_count <= '0;
        end else begin
            hdr_TREADY <= !full_next;

            case (state)
                WAIT_HDR: begin
                    if (accept) begin
                        if (drop_hdr) begin
                            if (drop_count != 16'hFFFF) begin
                                drop_count <= drop_count + 16'd1;
                            end
                        end else begin
                            hdr_user <= hdr_TDATA[ID_LSB-1:0];
                            hdr_id   <= hdr_TDATA[DEST_LSB-1:ID_LSB];
                            hdr_dest <= hdr_TDATA[LAST_BIT-1:DEST_LSB];
                            hdr_last <= hdr_TDATA[LAST_BIT];
                            state    <= WAIT_LAST;
                        end
                    end
                end
                WAIT_LAST: begin
                    if (accept && (HACK || hdr_TLAST)) begin
                        state <= WAIT_HDR;
                    end
                end
                default: state <= WAIT_HDR;
            endcase

            // Output register refills from the skid entry first to preserve order.
            if (out_free) begin
                if (skid_valid) begin
                    out_flit   <= skid_flit;
                    out_valid  <= 1'b1;
                    skid_valid <= push;
                    if (push) begin
                        skid_flit <= in_flit;
                    end
                end else begin
                    out_valid <= push;
                    if (push) begin
                        out_flit <= in_flit;
                    end
                end
            end else if (push) begin
                skid_flit  <= in_flit;
                skid_valid <= 1'b1;
            end
        end
    end

    assign sides_TDATA  = out_flit.data;
    assign sides_TKEEP  = out_flit.keep;
    assign sides_TLAST  = out_flit.last;
    assign sides_TDEST  = out_flit.dest;
    assign sides_TID    = out_flit.id;
    assign sides_TUSER  = out_flit.user;
    assign sides_TVALID = out_valid;

endmodule

// File: tb/tb_axis_deheaderizer.sv
// Directed-vector bench for axis_deheaderizer: cycle table, hack mode, mid-packet reset,
// randomly back-pressured scoreboard run and drop-counter saturation.
module tb_axis_deheaderizer;

    logic        clk;
    logic        rst;
    logic [63:0] hdr_TDATA;
    logic [7:0]  hdr_TKEEP;
    logic        hdr_TLAST;
    logic        hdr_TVALID;
    logic        hdr_TREADY;
    logic [63:0] sides_TDATA;
    logic [7:0]  sides_TKEEP;
    logic        sides_TLAST;
    logic        sides_TVALID;
    logic [15:0] sides_TDEST;
    logic [15:0] sides_TID;
    logic [7:0]  sides_TUSER;
    logic        sides_TREADY;
    logic [15:0] drop_count;

    logic [63:0] h_TDATA;
    logic [7:0]  h_TKEEP;
    logic        h_TLAST;
    logic        h_TVALID;
    logic        h_TREADY;
    logic [63:0] hs_TDATA;
    logic [7:0]  hs_TKEEP;
    logic        hs_TLAST;
    logic        hs_TVALID;
    logic [15:0] hs_TDEST;
    logic [15:0] hs_TID;
    logic [7:0]  hs_TUSER;
    logic        hs_TREADY;
    logic [15:0] h_drop_count;

    axis_deheaderizer dut (
        .clk(clk), .rst(rst),
        .hdr_TDATA(hdr_TDATA), .hdr_TKEEP(hdr_TKEEP), .hdr_TLAST(hdr_TLAST),
        .hdr_TVALID(hdr_TVALID), .hdr_TREADY(hdr_TREADY),
        .sides_TDATA(sides_TDATA), .sides_TKEEP(sides_TKEEP), .sides_TLAST(sides_TLAST),
        .sides_TVALID(sides_TVALID), .sides_TDEST(sides_TDEST), .sides_TID(sides_TID),
        .sides_TUSER(sides_TUSER), .sides_TREADY(sides_TREADY), .drop_count(drop_count)
    );

    axis_deheaderizer #(.ENABLE_TLAST_HACK(1)) dut_hack (
        .clk(clk), .rst(rst),
        .hdr_TDATA(h_TDATA), .hdr_TKEEP(h_TKEEP), .hdr_TLAST(h_TLAST),
        .hdr_TVALID(h_TVALID), .hdr_TREADY(h_TREADY),
        .sides_TDATA(hs_TDATA), .sides_TKEEP(hs_TKEEP), .sides_TLAST(hs_TLAST),
        .sides_TVALID(hs_TVALID), .sides_TDEST(hs_TDEST), .sides_TID(hs_TID),
        .sides_TUSER(hs_TUSER), .sides_TREADY(hs_TREADY), .drop_count(h_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic [7:0]  ik;
        logic        il;
        logic        ordy;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
        logic [15:0] edst;
        logic [15:0] eid;
        logic [7:0]  eu;
        logic        ehr;
        logic [15:0] edr;
    } vec_t;

    typedef logic [112:0] rec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t tbl[27];
    rec_t exp_q[$];
    bit   rnd_done = 0;
    bit   mon_done = 0;

    function automatic logic [63:0] mkh(logic [15:0] d, logic [15:0] i, logic [7:0] u, logic l);
        return {23'd0, l, d, i, u};
    endfunction

    function automatic vec_t mk(logic iv, logic [63:0] id, logic [7:0] ik, logic il, logic ordy,
                                logic ev, logic [63:0] ed, logic [7:0] ek, logic el,
                                logic [15:0] edst, logic [15:0] eid, logic [7:0] eu,
                                logic ehr, logic [15:0] edr);
        vec_t v;
        v.iv = iv; v.id = id; v.ik = ik; v.il = il; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ek = ek; v.el = el;
        v.edst = edst; v.eid = eid; v.eu = eu; v.ehr = ehr; v.edr = edr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic r);
        hdr_TVALID = v; hdr_TDATA = d; hdr_TKEEP = k; hdr_TLAST = l; sides_TREADY = r;
        tick();
    endtask

    task automatic hcyc(input logic v, input logic [63:0] d, input logic l);
        h_TVALID = v; h_TDATA = d; h_TKEEP = 8'hFF; h_TLAST = l; hs_TREADY = 1'b1;
        tick();
    endtask

    // Holds one input flit until it is accepted; flags a stuck ready as a failure.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, output bit ok);
        bit acc;
        hdr_TVALID = 1'b1; hdr_TDATA = d; hdr_TKEEP = k; hdr_TLAST = l;
        acc = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = hdr_TREADY;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        ok = acc;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        hdr_TVALID = 0; hdr_TDATA = '0; hdr_TKEEP = '0; hdr_TLAST = 0; sides_TREADY = 0;
        h_TVALID = 0; h_TDATA = '0; h_TKEEP = '0; h_TLAST = 0; hs_TREADY = 0;

        tbl[0]  = mk(0, 64'h0, 8'hFF, 0, 1,  0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[1]  = mk(1, mkh(16'h1234, 16'hABCD, 8'hEF, 1'b1), 8'hFF, 0, 1,
                     0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[2]  = mk(1, 64'hA0, 8'hFF, 0, 1,  1, 64'hA0, 8'hFF, 0, 16'h1234, 16'hABCD, 8'hEF, 1, 16'd0);
        tbl[3]  = mk(1, 64'hA1, 8'h0F, 1, 1,  1, 64'hA1, 8'h0F, 1, 16'h1234, 16'hABCD, 8'hEF, 1, 16'd0);
        tbl[4]  = mk(0, 64'h0, 8'hFF, 0, 1,  0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[5]  = mk(1, mkh(16'h0002, 16'h0022, 8'h02, 1'b0), 8'hFF, 0, 1,
                     0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[6]  = mk(1, 64'hB0, 8'hFF, 1, 1,  1, 64'hB0, 8'hFF, 1, 16'h0002, 16'h0022, 8'h02, 1, 16'd0);
        tbl[7]  = mk(1, mkh(16'h0003, 16'h0033, 8'h03, 1'b0), 8'hFF, 0, 1,
                     0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[8]  = mk(1, 64'hB1, 8'hFF, 1, 1,  1, 64'hB1, 8'hFF, 1, 16'h0003, 16'h0033, 8'h03, 1, 16'd0);
        tbl[9]  = mk(1, mkh(16'h0004, 16'h0044, 8'h04, 1'b0), 8'hFF, 0, 1,
                     0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[10] = mk(1, 64'hB2, 8'hFF, 1, 1,  1, 64'hB2, 8'hFF, 1, 16'h0004, 16'h0044, 8'h04, 1, 16'd0);
        tbl[11] = mk(0, 64'h0, 8'hFF, 0, 1,  0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[12] = mk(1, mkh(16'h0005, 16'h0055, 8'h05, 1'b0), 8'hFF, 0, 0,
                     0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[13] = mk(1, 64'hC0, 8'hFF, 0, 0,  1, 64'hC0, 8'hFF, 0, 16'h0005, 16'h0055, 8'h05, 1, 16'd0);
        tbl[14] = mk(1, 64'hC1, 8'h3F, 1, 0,  1, 64'hC0, 8'hFF, 0, 16'h0005, 16'h0055, 8'h05, 0, 16'd0);
        tbl[15] = mk(1, mkh(16'h0006, 16'h0066, 8'h06, 1'b0), 8'hFF, 0, 0,
                     1, 64'hC0, 8'hFF, 0, 16'h0005, 16'h0055, 8'h05, 0, 16'd0);
        tbl[16] = mk(1, mkh(16'h0006, 16'h0066, 8'h06, 1'b0), 8'hFF, 0, 1,
                     1, 64'hC1, 8'h3F, 1, 16'h0005, 16'h0055, 8'h05, 1, 16'd0);
        tbl[17] = mk(1, mkh(16'h0006, 16'h0066, 8'h06, 1'b0), 8'hFF, 0, 1,
                     0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[18] = mk(1, 64'hD0, 8'hFF, 1, 1,  1, 64'hD0, 8'hFF, 1, 16'h0006, 16'h0066, 8'h06, 1, 16'd0);
        tbl[19] = mk(1, mkh(16'h0007, 16'h0077, 8'h07, 1'b0), 8'hFF, 0, 0,
                     1, 64'hD0, 8'hFF, 1, 16'h0006, 16'h0066, 8'h06, 1, 16'd0);
        tbl[20] = mk(1, 64'hE0, 8'hFF, 1, 0,  1, 64'hD0, 8'hFF, 1, 16'h0006, 16'h0066, 8'h06, 0, 16'd0);
        tbl[21] = mk(0, 64'h0, 8'hFF, 0, 1,  1, 64'hE0, 8'hFF, 1, 16'h0007, 16'h0077, 8'h07, 1, 16'd0);
        tbl[22] = mk(0, 64'h0, 8'hFF, 0, 1,  0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd0);
        tbl[23] = mk(1, 64'hDEAD, 8'hFF, 1, 1, 0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd1);
        tbl[24] = mk(1, mkh(16'h0008, 16'h0088, 8'h08, 1'b0), 8'hFF, 0, 1,
                     0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd1);
        tbl[25] = mk(1, 64'hF0, 8'hFF, 1, 1,  1, 64'hF0, 8'hFF, 1, 16'h0008, 16'h0088, 8'h08, 1, 16'd1);
        tbl[26] = mk(0, 64'h0, 8'hFF, 0, 1,  0, 64'h0, 8'h00, 0, 16'h0, 16'h0, 8'h0, 1, 16'd1);

        // Reset state
        repeat (3) tick();
        chk("rst_hready", hdr_TREADY, 0);
        chk("rst_valid", sides_TVALID, 0);
        chk("rst_drops", drop_count, 0);
        rst = 1'b0;

        // Cycle-accurate directed table
        for (int i = 0; i < 27; i++) begin
            cyc(tbl[i].iv, tbl[i].id, tbl[i].ik, tbl[i].il, tbl[i].ordy);
            chk($sformatf("v%0d_valid", i), sides_TVALID, tbl[i].ev);
            chk($sformatf("v%0d_hready", i), hdr_TREADY, tbl[i].ehr);
            chk($sformatf("v%0d_drops", i), drop_count, tbl[i].edr);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_flit", i),
                    {sides_TDATA, sides_TKEEP, sides_TLAST, sides_TDEST, sides_TID, sides_TUSER},
                    {tbl[i].ed, tbl[i].ek, tbl[i].el, tbl[i].edst, tbl[i].eid, tbl[i].eu});
            end
        end
        cyc(0, 64'h0, 8'hFF, 0, 1);

        // Hack mode: TLAST comes from the header, every body flit closes the packet
        hcyc(1, mkh(16'h00A1, 16'h00B1, 8'hC1, 1'b0), 0);
        chk("hack_hdr1_valid", hs_TVALID, 0);
        hcyc(1, 64'h55, 0);
        chk("hack_body1", {hs_TVALID, hs_TDATA, hs_TLAST, hs_TDEST, hs_TID, hs_TUSER},
            {1'b1, 64'h55, 1'b0, 16'h00A1, 16'h00B1, 8'hC1});
        hcyc(1, mkh(16'h00A2, 16'h00B2, 8'hC2, 1'b1), 0);
        chk("hack_hdr2_valid", hs_TVALID, 0);
        hcyc(1, 64'h66, 0);
        chk("hack_body2", {hs_TVALID, hs_TDATA, hs_TLAST, hs_TDEST, hs_TID, hs_TUSER},
            {1'b1, 64'h66, 1'b1, 16'h00A2, 16'h00B2, 8'hC2});
        hcyc(1, mkh(16'h00A3, 16'h00B3, 8'hC3, 1'b0), 1);
        chk("hack_tlast_hdr_valid", hs_TVALID, 0);
        chk("hack_no_drop", h_drop_count, 0);
        hcyc(1, 64'h77, 1);
        chk("hack_body3", {hs_TVALID, hs_TDATA, hs_TLAST, hs_TDEST},
            {1'b1, 64'h77, 1'b0, 16'h00A3});
        hcyc(0, 64'h0, 0);
        chk("hack_idle_valid", hs_TVALID, 0);

        // Reset in the middle of a packet with a flit still buffered
        cyc(1, mkh(16'h0009, 16'h0099, 8'h09, 1'b0), 8'hFF, 0, 0);
        cyc(1, 64'hC0FFEE, 8'hFF, 0, 0);
        chk("mid_buffered", sides_TVALID, 1);
        rst = 1'b1;
        cyc(0, 64'h0, 8'hFF, 0, 0);
        chk("mid_rst_valid", sides_TVALID, 0);
        chk("mid_rst_drops", drop_count, 0);
        chk("mid_rst_hready", hdr_TREADY, 0);
        rst = 1'b0;
        cyc(0, 64'h0, 8'hFF, 0, 1);
        chk("mid_hready_up", hdr_TREADY, 1);
        cyc(1, mkh(16'h000A, 16'h00AA, 8'h0A, 1'b0), 8'hFF, 0, 1);
        chk("mid_hdr_valid", sides_TVALID, 0);
        cyc(1, 64'hBEEF, 8'hFF, 1, 1);
        chk("mid_body", {sides_TVALID, sides_TDATA, sides_TLAST, sides_TDEST, sides_TID, sides_TUSER},
            {1'b1, 64'hBEEF, 1'b1, 16'h000A, 16'h00AA, 8'h0A});
        cyc(0, 64'h0, 8'hFF, 0, 1);

        // Random backpressure against a scoreboard
        fork
            begin : drv
                bit ok;
                for (int p = 0; p < 1000; p++) begin
                    logic [15:0] d;
                    logic [15:0] idv;
                    logic [7:0]  u;
                    int nb;
                    d = 16'($urandom); idv = 16'($urandom); u = 8'($urandom);
                    nb = $urandom_range(1, 3);
                    send({23'($urandom), 1'($urandom), d, idv, u}, 8'($urandom), 1'b0, ok);
                    for (int b = 0; b < nb; b++) begin
                        logic [63:0] bd;
                        logic [7:0]  bk;
                        logic        bl;
                        bd = {32'($urandom), 32'($urandom)};
                        bk = 8'($urandom);
                        bl = (b == nb - 1);
                        send(bd, bk, bl, ok);
                        if (ok) exp_q.push_back({bd, bk, bl, d, idv, u});
                    end
                end
                hdr_TVALID = 1'b0;
                rnd_done = 1;
            end
            begin : rdy
                while (!mon_done) begin
                    @(posedge clk);
                    #1;
                    sides_TREADY = 1'($urandom_range(0, 1));
                end
                sides_TREADY = 1'b1;
            end
            begin : mon
                bit   prev_stall;
                rec_t held;
                rec_t cur;
                int   cycles;
                prev_stall = 0;
                held = '0;
                cycles = 0;
                while (!(rnd_done && exp_q.size() == 0) && cycles < 60000) begin
                    @(negedge clk);
                    cycles++;
                    cur = {sides_TDATA, sides_TKEEP, sides_TLAST, sides_TDEST, sides_TID, sides_TUSER};
                    if (prev_stall) begin
                        chk("stall_hold", {sides_TVALID, cur}, {1'b1, held});
                    end
                    if (sides_TVALID && sides_TREADY) begin
                        if (exp_q.size() == 0) begin
                            chk("rnd_extra_flit", 1, 0);
                        end else begin
                            chk("rnd_flit", cur, exp_q.pop_front());
                        end
                    end
                    prev_stall = sides_TVALID && !sides_TREADY;
                    held = cur;
                end
                chk("rnd_drained", exp_q.size(), 0);
                mon_done = 1;
            end
        join
        cyc(0, 64'h0, 8'hFF, 0, 1);
        chk("rnd_idle_valid", sides_TVALID, 0);

        // Empty-packet drops saturate the counter
        begin
            bit saw_out;
            saw_out = 0;
            hdr_TVALID = 1'b1; hdr_TDATA = 64'h1; hdr_TKEEP = 8'hFF; hdr_TLAST = 1'b1;
            for (int i = 0; i < 65540; i++) begin
                tick();
                if (sides_TVALID) saw_out = 1;
                if (i == 0) chk("drop_first", drop_count, 1);
            end
            chk("drop_no_output", saw_out, 0);
            chk("drop_saturated", drop_count, 16'hFFFF);
            hdr_TVALID = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
